// File: rtl/pf_stride_seq_if.sv
// Handshake bundle for pf_stride_seq: the op-side offer/retry channel and the
// per-pipe cache request channel. The sequencer is the slave.
interface pf_stride_seq_if #(
  parameter int unsigned NPIPES   = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned STRIDE_W = 8,
  parameter int unsigned CNT_W    = 4
);
  logic                op_valid;
  logic                op_retry;
  logic [ADDR_W-1:0]   op_base;
  logic [STRIDE_W-1:0] op_stride;
  logic [CNT_W-1:0]    op_count;
  logic                op_l2;

  logic [NPIPES-1:0]   req_valid;
  logic [NPIPES-1:0]   req_retry;
  logic [ADDR_W-1:0]   req_addr;
  logic                req_l2;

  // master: op producer plus the cache pipes; slave: the sequencer
  modport master (
    output op_valid, op_base, op_stride, op_count, op_l2, req_retry,
    input  op_retry, req_valid, req_addr, req_l2
  );

  modport slave (
    input  op_valid, op_base, op_stride, op_count, op_l2, req_retry,
    output op_retry, req_valid, req_addr, req_l2
  );
endinterface

// File: rtl/pf_stride_seq.sv
// Strided prefetch sequencer: expands one op into `count` line requests steered by
// line-address LSBs. Define PF_DROP_EN to drop requests retried MAX_RETRY cycles in a row.
module pf_stride_seq #(
  parameter int unsigned NPIPES    = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned STRIDE_W  = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned MAX_RETRY = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  pf_stride_seq_if.slave        bus,
  output logic                  op_done,
  output logic [15:0]           issued_cnt,
  output logic [15:0]           dropped_cnt
);
  localparam int unsigned PIPE_BITS = $clog2(NPIPES);

  if (NPIPES != 2 && NPIPES != 4) begin : g_bad_npipes
    $error("NPIPES must be 2 or 4");
  end
  if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_max_retry
    $error("MAX_RETRY must fit the 4-bit retry counter");
  end
  if (STRIDE_W >= ADDR_W) begin : g_bad_stride_w
    $error("STRIDE_W must be narrower than ADDR_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                l2_q, l2_d;
  logic                done_q, done_d;
  logic [15:0]         issued_q, issued_d;

  logic [PIPE_BITS-1:0] pipe_sel;
  logic [NPIPES-1:0]    pipe_onehot;
  logic                 last_req;

`ifdef PF_DROP_EN
  logic [3:0]          rtry_q, rtry_d;
  logic [15:0]         dropped_q, dropped_d;
`endif

  assign pipe_sel = addr_q[PIPE_BITS-1:0];
  assign last_req = (rem_q == CNT_W'(1));

  always_comb begin
    pipe_onehot = '0;
    for (int unsigned p = 0; p < NPIPES; p++) begin
      pipe_onehot[p] = (pipe_sel == PIPE_BITS'(p));
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    stride_d      = stride_q;
    rem_d         = rem_q;
    l2_d          = l2_q;
    done_d        = 1'b0;
    issued_d      = issued_q;
    bus.op_retry  = 1'b0;
    bus.req_valid = '0;
`ifdef PF_DROP_EN
    rtry_d        = rtry_q;
    dropped_d     = dropped_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.op_valid) begin
          if (bus.op_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = S_ISSUE;
            addr_d   = bus.op_base;
            stride_d = {{(ADDR_W-STRIDE_W){bus.op_stride[STRIDE_W-1]}}, bus.op_stride};
            rem_d    = bus.op_count;
            l2_d     = bus.op_l2;
`ifdef PF_DROP_EN
            rtry_d   = '0;
`endif
          end
        end
      end

      S_ISSUE: begin
        bus.op_retry  = 1'b1;
        bus.req_valid = pipe_onehot;
        if (!bus.req_retry[pipe_sel]) begin
          addr_d   = addr_q + stride_q;
          rem_d    = rem_q - CNT_W'(1);
          issued_d = (issued_q == 16'hFFFF) ? issued_q : issued_q + 16'd1;
          if (last_req) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
`ifdef PF_DROP_EN
          rtry_d = '0;
        end else begin
          // The limit-reaching retry cycle is still a plain hold; the drop happens next cycle.
          rtry_d = rtry_q + 4'd1;
          if (rtry_d == 4'(MAX_RETRY)) begin
            state_d = S_DROP;
          end
`endif
        end
      end

`ifdef PF_DROP_EN
      S_DROP: begin
        bus.op_retry = 1'b1;
        addr_d       = addr_q + stride_q;
        rem_d        = rem_q - CNT_W'(1);
        rtry_d       = '0;
        dropped_d    = (dropped_q == 16'hFFFF) ? dropped_q : dropped_q + 16'd1;
        if (last_req) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_ISSUE;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      rem_q    <= '0;
      l2_q     <= 1'b0;
      done_q   <= 1'b0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      rem_q    <= rem_d;
      l2_q     <= l2_d;
      done_q   <= done_d;
      issued_q <= issued_d;
    end
  end

`ifdef PF_DROP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rtry_q    <= '0;
      dropped_q <= '0;
    end else begin
      rtry_q    <= rtry_d;
      dropped_q <= dropped_d;
    end
  end

  assign dropped_cnt = dropped_q;
`else
  assign dropped_cnt = '0;
`endif

  assign bus.req_addr = addr_q;
  assign bus.req_l2   = l2_q;
  assign op_done      = done_q;
  assign issued_cnt   = issued_q;
endmodule

// File: tb/tb_pf_stride_seq.sv
// Scoreboard bench for pf_stride_seq: stimulus pushes expected requests, a negedge
// monitor pops and compares every transferred request and checks held requests stay stable.
module tb_pf_stride_seq;
  localparam int unsigned NPIPES    = 2;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned STRIDE_W  = 8;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MAX_RETRY = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_done;
  logic [15:0] issued_cnt;
  logic [15:0] dropped_cnt;

  always #5 clk = ~clk;

  pf_stride_seq_if #(.NPIPES(NPIPES), .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W), .CNT_W(CNT_W)) bus ();

  pf_stride_seq #(
    .NPIPES(NPIPES), .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W), .CNT_W(CNT_W), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .op_done(op_done), .issued_cnt(issued_cnt), .dropped_cnt(dropped_cnt)
  );

  typedef struct packed {
    logic [NPIPES-1:0] valid;
    logic              l2;
    logic [ADDR_W-1:0] addr;
  } req_t;

  req_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_issued = 0;
  int unsigned exp_dropped = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NPIPES-1:0] onehot_of(input logic [ADDR_W-1:0] a);
    logic [NPIPES-1:0] v;
    v = '0;
    v[a[0]] = 1'b1;
    return v;
  endfunction

  // Monitor: compares every transfer against the scoreboard, checks stability while held.
  logic held = 1'b0;
  req_t held_r;
  always @(negedge clk) begin
    req_t act;
    req_t e;
    act = '{valid: bus.req_valid, l2: bus.req_l2, addr: bus.req_addr};
    if (reset) begin
      held = 1'b0;
    end else if (bus.req_valid != '0) begin
      if (held) chk("hold_stable", act, held_r);
      if ((bus.req_valid & ~bus.req_retry) != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got valid=0x%0h addr=0x%0h, expected no request",
                   bus.req_valid, bus.req_addr);
        end else begin
          e = exp_q.pop_front();
          chk("req", act, e);
        end
        held = 1'b0;
      end else begin
        held   = 1'b1;
        held_r = act;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic send_op(input logic [ADDR_W-1:0] base, input logic [STRIDE_W-1:0] stride,
                         input logic [CNT_W-1:0] count, input logic l2, input bit push);
    int unsigned n = 0;
    logic [ADDR_W-1:0] a;
    bus.op_valid  = 1'b1;
    bus.op_base   = base;
    bus.op_stride = stride;
    bus.op_count  = count;
    bus.op_l2     = l2;
    @(negedge clk);
    while (bus.op_retry && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("op_accept", bus.op_retry, 1'b0);
    if (push) begin
      a = base;
      for (int unsigned i = 0; i < count; i++) begin
        exp_q.push_back('{valid: onehot_of(a), l2: l2, addr: a});
        a = a + {{(ADDR_W-STRIDE_W){stride[STRIDE_W-1]}}, stride};
      end
      exp_issued += count;
    end
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!op_done && n < 200);
    chk(name, op_done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    logic [ADDR_W-1:0] a;
    reset         = 1'b1;
    bus.op_valid  = 1'b0;
    bus.op_base   = '0;
    bus.op_stride = '0;
    bus.op_count  = '0;
    bus.op_l2     = 1'b0;
    bus.req_retry = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", bus.req_valid, '0);
    chk("rst_op_retry", bus.op_retry, 1'b0);
    chk("rst_req_addr", bus.req_addr, '0);
    chk("rst_op_done", op_done, 1'b0);
    chk("rst_issued", issued_cnt, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: ascending stride, exact cycle latency, alternating pipes
    send_op(32'h100, 8'd1, 4'd4, 1'b0, 1'b1);
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      a = 32'h100 + k;
      chk("t1_valid", bus.req_valid, onehot_of(a));
      chk("t1_addr", bus.req_addr, a);
    end
    @(negedge clk);
    chk("t1_done", op_done, 1'b1);
    chk("t1_idle_valid", bus.req_valid, '0);
    @(negedge clk);
    chk("t1_done_pulse", op_done, 1'b0);
    chk("t1_issued", issued_cnt, 16'd4);
    @(posedge clk);
    #1;

    // 2: negative stride down to and past zero
    send_op(32'h2, 8'hFF, 4'd3, 1'b1, 1'b1);
    wait_done("t2a_done");
    send_op(32'h0, 8'hFF, 4'd2, 1'b1, 1'b1);
    wait_done("t2b_done");
    chk("t2_issued", issued_cnt, 16'(exp_issued));

    // 3: retry held five cycles on the first request, no drop
    send_op(32'h10, 8'd2, 4'd3, 1'b0, 1'b1);
    bus.req_retry = 2'b01;
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", bus.req_valid, 2'b01);
      chk("t3_hold_addr", bus.req_addr, 32'h10);
    end
    @(posedge clk);
    #1;
    bus.req_retry = '0;
    wait_done("t3_done");
    chk("t3_issued", issued_cnt, 16'(exp_issued));
    chk("t3_dropped", dropped_cnt, 16'd0);

`ifdef PF_DROP_EN
    // 4: pipe 1 stuck in retry; 0x1 dropped after MAX_RETRY cycles, 0x2 issues on pipe 0
    bus.req_retry = 2'b10;
    send_op(32'h1, 8'd1, 4'd2, 1'b0, 1'b0);
    exp_q.push_back('{valid: 2'b01, l2: 1'b0, addr: 32'h2});
    exp_issued += 1;
    exp_dropped += 1;
    n = 0;
    @(negedge clk);
    while (bus.req_valid == 2'b10 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("t4_hold_cycles", n, MAX_RETRY);
    chk("t4_drop_gap", bus.req_valid, 2'b00);
    wait_done("t4_done");
    bus.req_retry = '0;
    chk("t4_dropped", dropped_cnt, 16'(exp_dropped));
    chk("t4_issued", issued_cnt, 16'(exp_issued));
`endif

    // 5: zero-count op, then op_valid held while issuing
    send_op(32'h40, 8'd1, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t5_zero_done", op_done, 1'b1);
    chk("t5_zero_valid", bus.req_valid, '0);
    @(negedge clk);
    chk("t5_zero_pulse", op_done, 1'b0);
    @(posedge clk);
    #1;
    send_op(32'h50, 8'd1, 4'd3, 1'b1, 1'b1);
    bus.op_valid = 1'b1;
    bus.op_base  = 32'h999;
    bus.op_count = 4'd5;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_busy_retry", bus.op_retry, 1'b1);
    end
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    wait_done("t5_done");
    chk("t5_issued", issued_cnt, 16'(exp_issued));

    // 6: reset after two of six requests, then a clean op
    send_op(32'h200, 8'd1, 4'd6, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6_rst_valid", bus.req_valid, '0);
    chk("t6_rst_retry", bus.op_retry, 1'b0);
    chk("t6_rst_addr", bus.req_addr, '0);
    chk("t6_rst_l2", bus.req_l2, 1'b0);
    chk("t6_rst_done", op_done, 1'b0);
    chk("t6_rst_issued", issued_cnt, 16'd0);
    chk("t6_rst_dropped", dropped_cnt, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_issued = 0;
    send_op(32'h300, 8'd3, 4'd2, 1'b1, 1'b1);
    @(negedge clk);
    chk("t6_new_addr", bus.req_addr, 32'h300);
    wait_done("t6_done");
    chk("t6_issued", issued_cnt, 16'(exp_issued));

    repeat (3) @(posedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
